// File: rtl/mem_arbiter.sv
// Purpose: single-port block-RAM arbiter between the fetch port and the MEM-stage load/store port.
// Latency: store acks 2 cycles after it is seen in IDLE; load or fetch acks 2+RD_LAT cycles after.
// Backpressure: requests are held by the requester until acked; stall_req holds the pipeline meanwhile.
//
// Ports:
//   clk, rst                       single clock, synchronous active-high reset
//   if_req/if_addr                 fetch request (held until if_ack)
//   if_ack/if_rdata                one-cycle ack pulse with fetched word
//   mem_op/mem_addr/mem_wdata      MEM-stage access (held until mem_ack); ops other than LW/SW are NOPs
//   mem_ack/mem_rdata              one-cycle ack pulse; rdata valid for loads
//   stall_req                      combinational pipeline stall request
//   ram_en/ram_we/ram_addr/ram_wdata  registered RAM controls
//   ram_rdata                      RAM read data, valid RD_LAT cycles after the ram_en cycle
module mem_arbiter #(
  parameter int          ADDR_W     = 14,
  parameter int          RD_LAT     = 1,
  parameter logic [2:0]  MEM_NOP_OP = 3'b000,
  parameter logic [2:0]  MEM_LW_OP  = 3'b001,
  parameter logic [2:0]  MEM_SW_OP  = 3'b010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic [2:0]        mem_op,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ack,
  output logic [31:0]       mem_rdata,
  output logic              stall_req,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Which port owns the access in flight and whether it writes.
  typedef struct packed {
    logic port_mem;
    logic wr;
  } gnt_t;

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t     state;
  gnt_t       gnt;
  logic [1:0] cnt;

  logic mem_is_lw;
  logic mem_is_sw;
  logic mem_vld;

  assign mem_is_lw = (mem_op == MEM_LW_OP);
  assign mem_is_sw = (mem_op == MEM_SW_OP);
  assign mem_vld   = mem_is_lw | mem_is_sw;

  // Drops in the ack cycle so the pipeline advances exactly once per access.
  assign stall_req = (if_req & ~if_ack) | (mem_vld & ~mem_ack);

  // Byte-offset bits and bits above the RAM size are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_W+2],
                              mem_addr[1:0], mem_addr[31:ADDR_W+2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      cnt       <= 2'd0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= 32'd0;
      mem_rdata <= 32'd0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          // MEM is the older instruction, so it wins; a losing fetch stays pending.
          if (mem_vld) begin
            gnt       <= '{port_mem: 1'b1, wr: mem_is_sw};
            ram_en    <= 1'b1;
            ram_we    <= mem_is_sw;
            ram_addr  <= mem_addr[ADDR_W+1:2];
            ram_wdata <= mem_is_sw ? mem_wdata : 32'd0;
            state     <= ISSUE;
          end else if (if_req) begin
            gnt       <= '{port_mem: 1'b0, wr: 1'b0};
            ram_en    <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= if_addr[ADDR_W+1:2];
            ram_wdata <= 32'd0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          if (gnt.wr) begin
            mem_ack <= 1'b1;
            state   <= DONE;
          end else begin
            // The ISSUE cycle counts as the first latency cycle already elapsed.
            cnt   <= 2'd1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == LAT) begin
            cnt <= 2'd0;
            if (gnt.port_mem) begin
              mem_rdata <= ram_rdata;
              mem_ack   <= 1'b1;
            end else begin
              if_rdata <= ram_rdata;
              if_ack   <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        DONE: begin
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed checks of mem_arbiter at RD_LAT=1 and RD_LAT=3 against behavioural RAMs.
// Latency: expected cycle counts are hand-derived from the access timing.
// Backpressure: requests are held until acked and dropped on the edge after the ack cycle.
module tb_mem_arbiter;

  localparam int         ADDR_W = 14;
  localparam logic [2:0] NOP    = 3'b000;
  localparam logic [2:0] LW     = 3'b001;
  localparam logic [2:0] SW     = 3'b010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus, routed to one DUT at a time by sel (0: RD_LAT=1, 1: RD_LAT=3).
  logic        sel = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [2:0]  mem_op = NOP;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;

  logic              a_if_req, b_if_req;
  logic [2:0]        a_mem_op, b_mem_op;
  logic              a_if_ack, b_if_ack, a_mem_ack, b_mem_ack, a_stall, b_stall;
  logic [31:0]       a_if_rdata, b_if_rdata, a_mem_rdata, b_mem_rdata;
  logic              a_en, b_en, a_we, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [31:0]       a_wdata, b_wdata, a_rdata, b_rdata;

  assign a_if_req = if_req & ~sel;
  assign b_if_req = if_req & sel;
  assign a_mem_op = sel ? NOP : mem_op;
  assign b_mem_op = sel ? mem_op : NOP;

  logic              o_if_ack, o_mem_ack, o_stall, o_en, o_we;
  logic [31:0]       o_if_rdata, o_mem_rdata, o_wdata;
  logic [ADDR_W-1:0] o_addr;
  assign o_if_ack    = sel ? b_if_ack    : a_if_ack;
  assign o_mem_ack   = sel ? b_mem_ack   : a_mem_ack;
  assign o_stall     = sel ? b_stall     : a_stall;
  assign o_en        = sel ? b_en        : a_en;
  assign o_we        = sel ? b_we        : a_we;
  assign o_if_rdata  = sel ? b_if_rdata  : a_if_rdata;
  assign o_mem_rdata = sel ? b_mem_rdata : a_mem_rdata;
  assign o_wdata     = sel ? b_wdata     : a_wdata;
  assign o_addr      = sel ? b_addr      : a_addr;

  mem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
    .mem_op(a_mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(a_mem_ack), .mem_rdata(a_mem_rdata), .stall_req(a_stall),
    .ram_en(a_en), .ram_we(a_we), .ram_addr(a_addr), .ram_wdata(a_wdata),
    .ram_rdata(a_rdata)
  );

  mem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .mem_op(b_mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata), .stall_req(b_stall),
    .ram_en(b_en), .ram_we(b_we), .ram_addr(b_addr), .ram_wdata(b_wdata),
    .ram_rdata(b_rdata)
  );

  // Behavioural RAMs; contents are preloaded while reset is held.
  logic [31:0] ram1 [0:(1<<ADDR_W)-1];
  logic [31:0] ram3 [0:(1<<ADDR_W)-1];
  logic [31:0] q3_0, q3_1;

  always @(posedge clk) begin
    if (rst) begin
      ram1[4] <= 32'h2402_0005;
      ram1[0] <= 32'h1111_2222;
    end else if (a_en && a_we) begin
      ram1[a_addr] <= a_wdata;
    end
    if (a_en) a_rdata <= ram1[a_addr];
  end

  always @(posedge clk) begin
    if (rst) begin
      ram3[14'h80] <= 32'hCAFE_F00D;
    end else if (b_en && b_we) begin
      ram3[b_addr] <= b_wdata;
    end
    if (b_en) q3_0 <= ram3[b_addr];
    q3_1    <= q3_0;
    b_rdata <= q3_1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Runs one access on the selected DUT, starting in an IDLE cycle just after a rising edge.
  // Returns just after the edge that ends the ack cycle, with the request dropped.
  task automatic xact(input string tag, input logic is_if, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [ADDR_W-1:0] exp_ra, input int exp_lat,
                      input logic [31:0] exp_rd);
    logic is_sw;
    logic ack;
    logic got;
    int   lat;
    is_sw = !is_if && (op == SW);
    got   = 1'b0;
    lat   = -1;
    if (is_if) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      mem_op    = op;
      mem_addr  = addr;
      mem_wdata = wdata;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, ".en"},    32'(o_en), 32'd1);
        check({tag, ".we"},    32'(o_we), 32'(is_sw));
        check({tag, ".raddr"}, 32'(o_addr), 32'(exp_ra));
        check({tag, ".wdata"}, o_wdata, is_sw ? wdata : 32'd0);
      end
      ack = is_if ? o_if_ack : o_mem_ack;
      check($sformatf("%s.stall%0d", tag, c), 32'(o_stall), 32'(!ack));
      if (ack) begin
        got = 1'b1;
        lat = c;
        check({tag, ".both"}, 32'(o_if_ack & o_mem_ack), 32'd0);
        if (!is_sw) check({tag, ".rdata"}, is_if ? o_if_rdata : o_mem_rdata, exp_rd);
      end
      @(posedge clk);
      #1;
      if (got) break;
    end
    if_req = 1'b0;
    mem_op = NOP;
    check({tag, ".acked"}, 32'(got), 32'd1);
    check({tag, ".lat"},   32'(lat), 32'(exp_lat));
  endtask

  // Starts a load, asserts reset in cycle rst_cyc (a WAIT cycle) and checks the reset outputs.
  task automatic load_reset(input string tag, input logic [31:0] addr, input int rst_cyc);
    mem_op   = LW;
    mem_addr = addr;
    for (int c = 0; c < rst_cyc; c++) begin
      @(posedge clk);
      #1;
    end
    rst    = 1'b1;
    mem_op = NOP;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check({tag, ".mem_ack"},   32'(o_mem_ack), 32'd0);
    check({tag, ".if_ack"},    32'(o_if_ack), 32'd0);
    check({tag, ".en"},        32'(o_en), 32'd0);
    check({tag, ".we"},        32'(o_we), 32'd0);
    check({tag, ".raddr"},     32'(o_addr), 32'd0);
    check({tag, ".wdata"},     o_wdata, 32'd0);
    check({tag, ".if_rdata"},  o_if_rdata, 32'd0);
    check({tag, ".mem_rdata"}, o_mem_rdata, 32'd0);
    check({tag, ".stall"},     32'(o_stall), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int m_at;
    int i_at;
    int en_last;
    logic ovl;
    logic en_seen;
    logic st_seen;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.if_ack",    32'(o_if_ack), 32'd0);
    check("rst.mem_ack",   32'(o_mem_ack), 32'd0);
    check("rst.en",        32'(o_en), 32'd0);
    check("rst.we",        32'(o_we), 32'd0);
    check("rst.raddr",     32'(o_addr), 32'd0);
    check("rst.wdata",     o_wdata, 32'd0);
    check("rst.if_rdata",  o_if_rdata, 32'd0);
    check("rst.mem_rdata", o_mem_rdata, 32'd0);
    check("rst.stall",     32'(o_stall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fetch of word 4, RD_LAT=1: ack in cycle 3.
    xact("fetch", 1'b1, NOP, 32'h0000_0010, 32'd0, 14'd4, 3, 32'h2402_0005);

    // Store then load of the same word.
    xact("sw", 1'b0, SW, 32'h0000_0100, 32'hDEAD_BEEF, 14'h40, 2, 32'd0);
    check("sw.ram", ram1[14'h40], 32'hDEAD_BEEF);
    check("sw.mem_rdata_kept", o_mem_rdata, 32'd0);
    xact("lw", 1'b0, LW, 32'h0000_0100, 32'd0, 14'h40, 3, 32'hDEAD_BEEF);
    check("lw.if_rdata_kept", o_if_rdata, 32'h2402_0005);

    // Fetch and load together: load first, fetch granted at the next IDLE.
    m_at = -1; i_at = -1; en_last = -1; ovl = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    mem_op = LW;   mem_addr = 32'h0000_0100;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (o_en) en_last = c;
      if (o_if_ack && o_mem_ack) ovl = 1'b1;
      if (o_mem_ack) begin
        m_at = c;
        check("cf.mem_rdata", o_mem_rdata, 32'hDEAD_BEEF);
        check("cf.stall_pending", 32'(o_stall), 32'd1);
      end
      if (o_if_ack) begin
        i_at = c;
        check("cf.if_rdata", o_if_rdata, 32'h2402_0005);
      end
      @(posedge clk);
      #1;
      if (m_at == c) mem_op = NOP;
      if (i_at == c) begin
        if_req = 1'b0;
        break;
      end
    end
    if_req = 1'b0;
    mem_op = NOP;
    check("cf.mem_ack_cyc", 32'(m_at), 32'd3);
    check("cf.fetch_en_cyc", 32'(en_last), 32'd5);
    check("cf.if_ack_cyc", 32'(i_at), 32'd7);
    check("cf.overlap", 32'(ovl), 32'd0);

    // Address wrap and byte offset dropped: 0x0001_0003 maps to word 0.
    xact("wrap", 1'b0, LW, 32'h0001_0003, 32'd0, 14'd0, 3, 32'h1111_2222);

    // Unknown op is a NOP: no RAM access and no stall.
    en_seen = 1'b0; st_seen = 1'b0;
    mem_op = 3'b111; mem_addr = 32'h0000_0100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (o_en) en_seen = 1'b1;
      if (o_stall) st_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    mem_op = NOP;
    check("nop.en", 32'(en_seen), 32'd0);
    check("nop.stall", 32'(st_seen), 32'd0);

    // Reset during WAIT (cycle 2 at RD_LAT=1), then a clean fetch.
    load_reset("rst1", 32'h0000_0100, 2);
    xact("fetch2", 1'b1, NOP, 32'h0000_0010, 32'd0, 14'd4, 3, 32'h2402_0005);

    // RD_LAT=3: load latency 5, reset during WAIT, then load again.
    sel = 1'b1;
    @(posedge clk);
    #1;
    xact("lat3", 1'b0, LW, 32'h0000_0200, 32'd0, 14'h80, 5, 32'hCAFE_F00D);
    load_reset("rst3", 32'h0000_0200, 3);
    xact("lat3b", 1'b0, LW, 32'h0000_0200, 32'd0, 14'h80, 5, 32'hCAFE_F00D);
    xact("lat3sw", 1'b0, SW, 32'h0000_0204, 32'h0BAD_CAFE, 14'h81, 2, 32'd0);
    xact("lat3f", 1'b1, NOP, 32'h0000_0204, 32'd0, 14'h81, 5, 32'h0BAD_CAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and sequencer between the instruction-fetch stage and the MEM stage of the pipelined CPU. It serialises fetch reads and data loads/stores onto one synchronous block RAM with configurable read latency, returns read data with a one-cycle acknowledge, and drives a pipeline stall request while any access is outstanding. It consumes the `mem_op`/`mem_addr`/`mem_data` triple that the EXE stage produces, after the EX/MEM register.

## Interface
- `ADDR_W`, 14: RAM word-address width (RAM holds 2^ADDR_W 32-bit words).
- `RD_LAT`, 1: RAM read latency in cycles, legal range 1..3.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request, held until `if_ack`.
- `if_addr` in 32: fetch byte address.
- `if_ack` out 1: one-cycle pulse, `if_rdata` is valid.
- `if_rdata` out 32: fetched instruction word.
- `mem_op` in 3: `MEM_NOP_OP` / `MEM_LW_OP` / `MEM_SW_OP` from `defines.v`, held until `mem_ack`.
- `mem_addr` in 32: data byte address.
- `mem_wdata` in 32: store data.
- `mem_ack` out 1: one-cycle pulse, access complete; `mem_rdata` is valid for LW.
- `mem_rdata` out 32: load data.
- `stall_req` out 1: pipeline stall request.
- `ram_en` out 1, `ram_we` out 1, `ram_addr` out ADDR_W, `ram_wdata` out 32: registered RAM controls.
- `ram_rdata` in 32: RAM read data, valid RD_LAT cycles after the `ram_en` cycle.

## Operation
- FSM states:
  - IDLE: samples requests and grants one.
  - ISSUE: drives `ram_en` for one cycle.
  - WAIT: counts RD_LAT cycles, loads and fetches only.
  - DONE: drives the ack and ignores requests.
- Transitions:
  - IDLE→ISSUE on any valid request.
  - ISSUE→DONE for a store.
  - ISSUE→WAIT for a read.
  - WAIT→DONE when the count reaches RD_LAT; `ram_rdata` is captured into the granted rdata register on that edge.
  - DONE→IDLE unconditionally.
- Priority: the MEM stage always wins over fetch in IDLE, because it is the older instruction. The losing request stays pending and is not dropped.
- `mem_op` values other than LW/SW are treated as NOP: no grant and no stall.
- Address mapping:
  - `ram_addr = addr[ADDR_W+1:2]`.
  - `addr[1:0]` is ignored, so accesses are word aligned.
  - Bits above ADDR_W+1 are ignored, so addresses wrap modulo the RAM size.
- Request inputs are latched into internal registers at grant. Input changes after grant do not affect the access in flight.
- `stall_req = (if_req & ~if_ack) | (mem_op∈{LW,SW} & ~mem_ack)`. It is combinational and drops in the ack cycle so the pipeline advances exactly once.
- `if_rdata`/`mem_rdata` hold their last captured value until the next capture of the same port.
- A store never updates `mem_rdata`.
- `ram_we` is high only in the ISSUE cycle of a store. `ram_wdata` is the latched `mem_wdata`. `ram_wdata` is 0 for reads.
- Reset values: state IDLE, counter 0, and all outputs 0: `if_ack`, `mem_ack`, `if_rdata`, `mem_rdata`, all `ram_*`. `stall_req` follows its equation from the zeroed acks.
- Reset mid-operation:
  - The access is abandoned and no ack is issued.
  - `ram_en`/`ram_we` are 0 from the cycle after the reset edge.
  - A store already issued is not undone.

## Timing
Cycle 0 is the first cycle a request is seen in IDLE.
- Store: `ram_en=ram_we=1` in cycle 1; `mem_ack` in cycle 2. Latency is 2 cycles.
- Load or fetch:
  - `ram_en=1` in cycle 1.
  - `ram_rdata` is sampled at the end of cycle 1+RD_LAT.
  - Ack and data are valid in cycle 2+RD_LAT.
- Back-to-back:
  - IDLE resumes in the cycle after DONE.
  - Throughput is one store per 3 cycles or one read per 3+RD_LAT cycles.
- Simultaneous `mem_op` and `if_req`:
  - MEM is served first.
  - Fetch is granted at the next IDLE, provided no new MEM request is present.
- Both acks are never high in the same cycle.

## Test plan
- Reset, then one fetch with RD_LAT=1: `if_req=1`, `if_addr=0x0000_0010`, RAM word 4 = 0x2402_0005 → `ram_en` in cycle 1 with `ram_addr=4`, then `if_ack=1` and `if_rdata=0x2402_0005` in cycle 3. `stall_req` is high in cycles 0–2 and low in cycle 3.
- Store then load:
  - SW to 0x0000_0100 with data 0xDEAD_BEEF → `ram_we` in cycle 1 with `ram_addr=0x40`, then `mem_ack` in cycle 2.
  - LW from the same address, issued next → `mem_rdata=0xDEAD_BEEF` and `mem_ack` at latency 3. `if_rdata` is unchanged.
- Conflict: `if_req` and LW both asserted in cycle 0 → `mem_ack` in cycle 3, fetch `ram_en` in cycle 5, `if_ack` in cycle 7. The two acks never overlap.
- Wrap and alignment with ADDR_W=14: LW to 0x0001_0003 → `ram_addr=0`.
- Invalid `mem_op=3'b111` → no `ram_en`, `stall_req=0`.
- Reset mid-load: `rst` asserted during WAIT → no `mem_ack`, all outputs 0 next cycle, and a new fetch after release completes normally. Repeat with RD_LAT=3 and confirm load latency 5.
